// File: rtl/direct_sound_fifo_channel.sv
`default_nettype none
// ============================================================================
// Module      : direct_sound_fifo_channel
// Description : GBA Direct Sound channel with integrated 32-bit sample FIFO.
//               Optional build macro DS_UNDERFLOW_HOLD_EN holds the last
//               sample on underflow instead of driving 0.
// Revision    : 1.0 - initial release
// ============================================================================
module direct_sound_fifo_channel #(
  parameter int FIFO_DEPTH = 8,
  parameter int SAMPLE_W   = 8,
  parameter int OUT_W      = 24,
  parameter int REQ_LEVEL  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [15:0]                   TM0_CNT_L,
  input  logic [15:0]                   TM1_CNT_L,
  input  logic                          timer_num,
  input  logic                          output_l,
  input  logic                          output_r,
  input  logic                          volume_full,
  input  logic                          fifo_clr,
  input  logic                          wr_en,
  input  logic [31:0]                   wr_data,
  output logic [OUT_W-1:0]              waveout,
  output logic                          sound_req,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow
);

  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_LVL_W  = c_PTR_W + 1;
  localparam int c_WORD_W = 4 * SAMPLE_W;
  localparam logic [c_LVL_W-1:0] c_DEPTH = c_LVL_W'(FIFO_DEPTH);
  localparam logic [c_LVL_W-1:0] c_REQ   = c_LVL_W'(REQ_LEVEL);
  localparam logic [c_LVL_W-1:0] c_ONE   = c_LVL_W'(1);
  localparam logic [c_PTR_W-1:0] c_PINC  = c_PTR_W'(1);

  logic [c_WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_LVL_W-1:0]  r_level;
  logic [1:0]          r_byte_idx;
  logic [c_WORD_W-1:0] r_shift;
  logic [15:0]         r_prev_timer;
  logic [OUT_W-1:0]    r_waveout;
  logic                r_sound_req;
  logic                r_underflow;

  logic [15:0]         w_timer;
  logic                w_enabled;
  logic                w_tick;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic [SAMPLE_W-1:0] w_sample;
  logic [OUT_W-1:0]    w_scaled_full;
  logic [OUT_W-1:0]    w_scaled;

  assign w_timer   = timer_num ? TM1_CNT_L : TM0_CNT_L;
  assign w_enabled = output_l | output_r;
  assign w_tick    = w_enabled & (r_prev_timer > w_timer);
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == c_DEPTH);
  // fifo_clr wins over both pop and write in the same cycle
  assign w_pop     = w_tick & (r_byte_idx == 2'd0) & ~w_empty & ~fifo_clr;
  assign w_push    = wr_en & ~fifo_clr & (~w_full | w_pop);

  always_comb begin
    w_sample = '0;
    case (r_byte_idx)
      2'd0:    w_sample = r_mem[r_rd_ptr][SAMPLE_W-1:0];
      2'd1:    w_sample = r_shift[2*SAMPLE_W-1:SAMPLE_W];
      2'd2:    w_sample = r_shift[3*SAMPLE_W-1:2*SAMPLE_W];
      default: w_sample = r_shift[4*SAMPLE_W-1:3*SAMPLE_W];
    endcase
  end

  assign w_scaled_full = {w_sample, {(OUT_W-SAMPLE_W){1'b0}}};
  assign w_scaled      = volume_full ? w_scaled_full
                                     : {w_scaled_full[OUT_W-1], w_scaled_full[OUT_W-1:1]};

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_byte_idx   <= 2'd0;
      r_shift      <= '0;
      r_prev_timer <= '0;
      r_waveout    <= '0;
      r_sound_req  <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_prev_timer <= w_timer;
      r_sound_req  <= 1'b0;
      r_underflow  <= 1'b0;
      if (fifo_clr) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_level    <= '0;
        r_byte_idx <= 2'd0;
        r_waveout  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + c_PINC;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PINC;
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + c_ONE;
          2'b01:   r_level <= r_level - c_ONE;
          default: r_level <= r_level;
        endcase

        if (!w_enabled) begin
          r_byte_idx <= 2'd0;
          r_waveout  <= '0;
        end else if (w_tick) begin
          if (r_byte_idx == 2'd0) begin
            if (!w_empty) begin
              r_shift     <= r_mem[r_rd_ptr];
              r_waveout   <= w_scaled;
              r_byte_idx  <= 2'd1;
              r_sound_req <= ((r_level - c_ONE) <= c_REQ);
            end else begin
              r_underflow <= 1'b1;
`ifndef DS_UNDERFLOW_HOLD_EN
              r_waveout   <= '0;
`endif
            end
          end else begin
            r_waveout  <= w_scaled;
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end
      end
    end
  end

  assign waveout    = r_waveout;
  assign sound_req  = r_sound_req;
  assign fifo_level = r_level;
  assign underflow  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_direct_sound_fifo_channel.sv
`default_nettype none
// ============================================================================
// Module      : tb_direct_sound_fifo_channel
// Description : Scoreboard bench for direct_sound_fifo_channel; a queue-based
//               playback model predicts every cycle's outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_direct_sound_fifo_channel;

  localparam int DEPTH = 8;
  localparam int REQ   = 4;

  typedef struct {
    logic [23:0] wave;
    logic        req;
    logic        ur;
    logic [3:0]  lvl;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, timer_num, output_l, output_r, volume_full, fifo_clr, wr_en;
  logic [15:0] tm0, tm1;
  logic [31:0] wr_data;
  logic [23:0] waveout;
  logic        sound_req, underflow;
  logic [3:0]  fifo_level;

  // staged stimulus, applied at the next falling edge
  logic        s_rst, s_tnum, s_ol, s_or, s_vol, s_clr, s_wr;
  logic [15:0] s_tm0, s_tm1;
  logic [31:0] s_wdata;

  // reference model state
  logic [31:0] m_fifo[$];
  logic [31:0] m_word;
  int          m_pos;
  logic [15:0] m_prev;
  logic [23:0] m_wave;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  direct_sound_fifo_channel dut (
    .clock(clk), .reset(reset), .TM0_CNT_L(tm0), .TM1_CNT_L(tm1),
    .timer_num(timer_num), .output_l(output_l), .output_r(output_r),
    .volume_full(volume_full), .fifo_clr(fifo_clr), .wr_en(wr_en),
    .wr_data(wr_data), .waveout(waveout), .sound_req(sound_req),
    .fifo_level(fifo_level), .underflow(underflow)
  );

  function automatic logic [23:0] scale(input logic [7:0] b, input logic vol);
    int v;
    v = (b >= 8'd128) ? (int'(b) - 256) : int'(b);
    v = v * 65536;
    if (!vol) v = v / 2;
    return v[23:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    exp_t        e;
    logic [15:0] sel;
    logic        en, tk;
    @(negedge clk);
    reset = s_rst; timer_num = s_tnum; output_l = s_ol; output_r = s_or;
    volume_full = s_vol; fifo_clr = s_clr; wr_en = s_wr; wr_data = s_wdata;
    tm0 = s_tm0; tm1 = s_tm1;
    sel  = s_tnum ? s_tm1 : s_tm0;
    en   = s_ol | s_or;
    tk   = en && (m_prev > sel);
    e.req = 1'b0;
    e.ur  = 1'b0;
    if (s_rst) begin
      m_fifo.delete(); m_pos = 0; m_word = '0; m_wave = '0; m_prev = '0;
    end else begin
      m_prev = sel;
      if (s_clr) begin
        m_fifo.delete(); m_pos = 0; m_wave = '0;
      end else begin
        if (!en) begin
          m_pos = 0; m_wave = '0;
        end else if (tk) begin
          if (m_pos == 0 && m_fifo.size() == 0) begin
            e.ur = 1'b1;
`ifndef DS_UNDERFLOW_HOLD_EN
            m_wave = '0;
`endif
          end else begin
            if (m_pos == 0) begin
              m_word = m_fifo.pop_front();
              e.req  = (m_fifo.size() <= REQ);
            end
            m_wave = scale(8'((m_word >> (8 * m_pos)) & 32'hFF), s_vol);
            m_pos  = (m_pos + 1) % 4;
          end
        end
        if (s_wr && m_fifo.size() < DEPTH) m_fifo.push_back(s_wdata);
      end
    end
    e.wave = m_wave;
    e.lvl  = 4'(m_fifo.size());
    exp_q.push_back(e);
  endtask

  task automatic write_word(input logic [31:0] d);
    s_wr = 1'b1; s_wdata = d; step(); s_wr = 1'b0;
  endtask

  // timer 0 reload to 0xFFFF then wrap to 0 gives exactly one tick
  task automatic tick0(input logic wr, input logic [31:0] d);
    s_tm0 = 16'hFFFF; step();
    s_tm0 = 16'h0000; s_wr = wr; s_wdata = d; step(); s_wr = 1'b0;
  endtask

  // monitor: one expectation per cycle, checked just after the active edge
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("waveout",    {8'h0, waveout},   {8'h0, e.wave});
      check("sound_req",  {31'h0, sound_req}, {31'h0, e.req});
      check("underflow",  {31'h0, underflow}, {31'h0, e.ur});
      check("fifo_level", {28'h0, fifo_level}, {28'h0, e.lvl});
    end
  end

  initial begin
    s_rst = 1'b1; s_tnum = 1'b0; s_ol = 1'b0; s_or = 1'b0; s_vol = 1'b1;
    s_clr = 1'b0; s_wr = 1'b0; s_tm0 = '0; s_tm1 = '0; s_wdata = '0;
    reset = 1'b1; timer_num = 1'b0; output_l = 1'b0; output_r = 1'b0;
    volume_full = 1'b1; fifo_clr = 1'b0; wr_en = 1'b0; wr_data = '0;
    tm0 = '0; tm1 = '0;
    m_pos = 0; m_word = '0; m_prev = '0; m_wave = '0;
    repeat (3) step();
    s_rst = 1'b0;
    step();

    // full-volume playback of one word
    s_ol = 1'b1; s_vol = 1'b1;
    write_word(32'h807F0102);
    repeat (4) tick0(1'b0, '0);
    step();

    // half volume
    s_vol = 1'b0;
    write_word(32'h807F0102);
    repeat (4) tick0(1'b0, '0);
    s_vol = 1'b1;

    // fill, overflow drop, write on a popping tick while full
    for (int i = 0; i < DEPTH; i++) write_word(32'h01010101 * (i + 1));
    write_word(32'hDEADBEEF);
    step();
    tick0(1'b1, 32'hCAFEF00D);
    for (int i = 0; i < 4 * DEPTH + 3; i++) tick0(1'b0, '0);

    // underflow on an empty FIFO
    tick0(1'b0, '0);
    step();

    // fifo_clr mid-word together with a write
    write_word(32'hA1B2C3D4);
    tick0(1'b0, '0);
    tick0(1'b0, '0);
    s_clr = 1'b1; s_wr = 1'b1; s_wdata = 32'h55555555; step();
    s_clr = 1'b0; s_wr = 1'b0;
    write_word(32'h44332211);
    tick0(1'b0, '0);
    tick0(1'b0, '0);

    // switch to timer 1 falling while timer 0 is static
    write_word(32'h0F0E0D0C);
    write_word(32'h1B1A1918);
    s_tm0 = 16'h8000; s_tm1 = 16'h9000; step();
    s_tnum = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_tm1 = s_tm1 - 16'd1; step(); step();
    end

    // both enables off: no pops, waveout forced to 0
    s_ol = 1'b0; s_or = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_tm1 = s_tm1 - 16'd1; step();
    end
    s_tnum = 1'b0; s_tm0 = 16'h0000; step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s_rst = ($urandom_range(0, 499) == 0);
      s_clr = ($urandom_range(0, 99) == 0);
      s_wr  = (i < 1500) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0);
      s_wdata = $urandom;
      s_ol  = ($urandom_range(0, 9) != 0);
      s_or  = $urandom_range(0, 1) == 1;
      s_vol = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 99) == 0) s_tnum = ~s_tnum;
      if ($urandom_range(0, 3) == 0) s_tm0 = s_tm0 - 16'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) s_tm1 = s_tm1 - 16'($urandom_range(1, 3));
      if ($urandom_range(0, 49) == 0) s_tm0 = 16'($urandom);
      if ($urandom_range(0, 49) == 0) s_tm1 = 16'($urandom);
      step();
    end
    s_rst = 1'b0; s_clr = 1'b0; s_wr = 1'b0;

    repeat (4) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
